// File: rtl/multi_lane_calc_pipe.sv
// multi_lane_calc_pipe: LANES-wide two-stage valid/ready ALU pipeline with per-lane accumulators
module multi_lane_calc_pipe #(
  parameter int W     = 3,
  parameter int LANES = 3,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [LANES*3-1:0] in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_res,
  output logic [LANES-1:0]   out_flag,
  output logic [CW-1:0]      txn_cnt
);
  logic s1_valid_q, s2_valid_q, ready_s1, ready_s2, accept, advance;
  logic [LANES*W-1:0] a_q, b_q;
  logic [LANES*3-1:0] op_q;
  logic [CW-1:0] cnt_q;
  assign ready_s2  = !s2_valid_q | out_ready;
  assign ready_s1  = !s1_valid_q | ready_s2;
  assign in_ready  = ready_s1;
  assign accept    = in_valid & ready_s1;
  assign advance   = s1_valid_q & ready_s2;
  assign out_valid = s2_valid_q;
  assign txn_cnt   = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
    end else begin
      if (ready_s1) s1_valid_q <= in_valid;
      if (ready_s2) s2_valid_q <= s1_valid_q;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        op_q  <= in_op;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] a, b, acc_q, res_q, res_d;
    logic [2:0] op;
    logic flag_q, flag_d;
    logic [W:0] sum, dif, accs;
    logic [2*W-1:0] prod;
    assign a    = a_q[i*W +: W];
    assign b    = b_q[i*W +: W];
    assign op   = op_q[i*3 +: 3];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign dif  = {1'b0, a} - {1'b0, b};
    assign accs = {1'b0, acc_q} + {1'b0, a};
    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    always_comb begin
      res_d  = sum[W-1:0];
      flag_d = 1'b0;
      case (op)
        3'd0: flag_d = sum[W];
        3'd1: begin res_d = dif[W-1:0]; flag_d = dif[W]; end
        3'd2: res_d = a & b;
        3'd3: res_d = a | b;
        3'd4: res_d = a ^ b;
        3'd5: begin res_d = prod[W-1:0]; flag_d = |prod[2*W-1:W]; end
        3'd6: res_d = a;
        default: begin res_d = accs[W-1:0]; flag_d = accs[W]; end
      endcase
    end
    // acc lives in the compute stage, so it only moves when a bundle leaves S1
    always_ff @(posedge clk) begin
      if (rst) begin
        res_q  <= '0;
        flag_q <= 1'b0;
        acc_q  <= '0;
      end else if (advance) begin
        res_q  <= res_d;
        flag_q <= flag_d;
        if (op[2:1] == 2'b11) acc_q <= op[0] ? accs[W-1:0] : a;
      end
    end
    assign out_res[i*W +: W] = res_q;
    assign out_flag[i]       = flag_q;
  end
endmodule

// File: tb/tb_multi_lane_calc_pipe.sv
// tb_multi_lane_calc_pipe: randomized scoreboard bench against a per-lane arithmetic reference model
module tb_multi_lane_calc_pipe;
  localparam int W = 3, L = 3, CW = 8;
  typedef struct packed {
    logic [L*W-1:0] res;
    logic [L-1:0]   flag;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [L*W-1:0] in_a = '0, in_b = '0, out_res, out_res2;
  logic [L*3-1:0] in_op = '0;
  logic [L-1:0] out_flag, out_flag2;
  logic [CW-1:0] txn_cnt;
  logic [1:0] txn_cnt2;
  exp_t q[$];
  int acc_m[L];
  int cnt = 0, n_cmp = 0, n_err = 0;
  bit a1, a2, a3;
  logic [L*W-1:0] ra, rb;
  logic [L*3-1:0] rop;

  multi_lane_calc_pipe #(.W(W), .LANES(L), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_flag(out_flag), .txn_cnt(txn_cnt));
  multi_lane_calc_pipe #(.W(W), .LANES(L), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_res(out_res2), .out_flag(out_flag2), .txn_cnt(txn_cnt2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void ref_lane(input int a, input int b, input int op, inout int acc,
                                   output int r, output bit f);
    int m = 1 << W;
    f = 1'b0;
    case (op)
      0: begin r = a + b; f = r >= m; end
      1: begin r = a - b + m; f = a < b; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * b; f = r >= m; end
      6: begin acc = a; r = a; end
      default: begin r = acc + a; f = r >= m; acc = r % m; end
    endcase
    r = r % m;
  endfunction

  task automatic cyc(input logic v, input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                     input logic [L*3-1:0] op, input logic ordy, output bit acc);
    exp_t e;
    int r;
    bit f;
    @(posedge clk);
    #1;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
    @(negedge clk);
    chk("txn_cnt", 32'(txn_cnt), 32'(cnt % 256));
    chk("txn_cnt_cw2", 32'(txn_cnt2), 32'(cnt % 4));
    chk("in_ready", 32'(in_ready), 32'(ordy || q.size() < 2));
    acc = v && in_ready;
    if (acc) begin
      for (int l = 0; l < L; l++) begin
        ref_lane(int'(a[l*W +: W]), int'(b[l*W +: W]), int'(op[l*3 +: 3]), acc_m[l], r, f);
        e.res[l*W +: W] = W'(r);
        e.flag[l] = f;
      end
      q.push_back(e);
      cnt++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'($urandom_range(0, 1)); out_ready = 1'b1;
    @(negedge clk);
    q.delete();
    foreach (acc_m[l]) acc_m[l] = 0;
    cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_txn_cnt", 32'(txn_cnt), 0);
    chk("rst_out_res", 32'(out_res), 0);
    chk("rst_out_flag", 32'(out_flag), 0);
  endtask

  task automatic rnd();
    ra = (L*W)'($urandom); rb = (L*W)'($urandom); rop = (L*3)'($urandom);
  endtask

  initial begin : monitor
    exp_t e;
    bit held_v = 1'b0;
    logic [L*W-1:0] held_res;
    logic [L-1:0] held_flag;
    forever begin
      @(negedge clk);
      if (rst) held_v = 1'b0;
      else if (out_valid) begin
        if (held_v) begin
          chk("stall_res_hold", 32'(out_res), 32'(held_res));
          chk("stall_flag_hold", 32'(out_flag), 32'(held_flag));
        end
        if (out_ready) begin
          held_v = 1'b0;
          if (q.size() == 0) chk("unexpected_output", 32'(out_valid), 0);
          else begin
            e = q.pop_front();
            chk("out_res", 32'(out_res), 32'(e.res));
            chk("out_flag", 32'(out_flag), 32'(e.flag));
          end
        end else begin
          held_v = 1'b1; held_res = out_res; held_flag = out_flag;
        end
      end
    end
  end

  initial begin
    foreach (acc_m[l]) acc_m[l] = 0;
    repeat (2) @(posedge clk);
    do_reset();
    // lanes: ADD, SUB, MUL with a=5, b=4 -> 1/1/4, flags 1/0/1
    cyc(1, {3'd5, 3'd5, 3'd5}, {3'd4, 3'd4, 3'd4}, {3'd5, 3'd1, 3'd0}, 1, a1);
    cyc(0, '0, '0, '0, 1, a2);
    chk("latency_not_yet", 32'(out_valid), 0);
    cyc(0, '0, '0, '0, 1, a2);
    chk("latency_valid", 32'(out_valid), 1);
    chk("t1_res", 32'(out_res), 32'({3'd4, 3'd1, 3'd1}));
    chk("t1_flag", 32'(out_flag), 32'(3'b101));
    for (int k = 0; k < 4; k++) begin
      rnd();
      cyc(1, ra, rb, rop, 1, a1);
      chk("stream_accept", 32'(a1), 1);
    end
    repeat (3) cyc(0, '0, '0, '0, 1, a1);
    // backpressure: third bundle refused until out_ready returns
    rnd();
    cyc(1, ra, rb, rop, 0, a1);
    rnd();
    cyc(1, ra, rb, rop, 0, a2);
    rnd();
    cyc(1, ra, rb, rop, 0, a3);
    chk("stall_accepts", 32'({a1, a2, a3}), 32'(3'b110));
    cyc(0, '0, '0, '0, 0, a1);
    cyc(1, ra, rb, rop, 1, a3);
    chk("stall_release_accept", 32'(a3), 1);
    repeat (4) cyc(0, '0, '0, '0, 1, a1);
    // lane0 accumulator chain 2, 5, 1 with a stall between the last two
    rnd();
    cyc(1, {ra[L*W-1:W], 3'd2}, rb, {rop[L*3-1:3], 3'd6}, 1, a1);
    rnd();
    cyc(1, {ra[L*W-1:W], 3'd3}, rb, {rop[L*3-1:3], 3'd7}, 0, a1);
    repeat (3) cyc(0, '0, '0, '0, 0, a1);
    rnd();
    cyc(1, {ra[L*W-1:W], 3'd4}, rb, {rop[L*3-1:3], 3'd7}, 1, a1);
    repeat (4) cyc(0, '0, '0, '0, 1, a1);
    chk("acc0_model", 32'(acc_m[0]), 1);
    rnd();
    cyc(1, {ra[L*W-1:W], 3'd0}, rb, {rop[L*3-1:3], 3'd7}, 1, a1);
    repeat (2) cyc(0, '0, '0, '0, 1, a1);
    chk("acc0_readback", 32'(out_res[W-1:0]), 1);
    // reset with both stages full
    rnd();
    cyc(1, ra, rb, rop, 0, a1);
    rnd();
    cyc(1, ra, rb, rop, 0, a1);
    do_reset();
    cyc(1, 9'o111, '0, {3'd7, 3'd7, 3'd7}, 1, a1);
    repeat (2) cyc(0, '0, '0, '0, 1, a1);
    chk("acc_after_rst", 32'(out_res), 32'(9'o111));
    for (int k = 0; k < 800; k++) begin
      rnd();
      cyc(1'($urandom_range(0, 3) != 0), ra, rb, rop, 1'($urandom_range(0, 3) != 0), a1);
    end
    repeat (8) cyc(0, '0, '0, '0, 1, a1);
    chk("drain_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
